// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter between the CPU and an external host.
// The CPU wins by default; a waiting host is forced through after STARVE_MAX CPU-won cycles.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [14:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_gnt,
    output logic [15:0] host_rdata,
    output logic        host_rvalid,
    output logic [14:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt_r;
    logic [15:0] host_rdata_r;
    logic        host_rvalid_r;
    logic        host_win_s;

    assign cpu_rdata   = ram_rdata;
    assign host_rdata  = host_rdata_r;
    assign host_rvalid = host_rvalid_r;

    // Ownership decision and RAM port steering; reset silences every strobe at once.
    always_comb begin
        host_win_s = 1'b0;
        ram_addr   = cpu_addr;
        ram_wdata  = cpu_wdata;
        ram_we     = 1'b0;
        if (reset_n && host_req && (!cpu_req || (starve_cnt_r == STARVE_LIMIT))) begin
            host_win_s = 1'b1;
        end else begin
            host_win_s = 1'b0;
        end
        if (host_win_s) begin
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
            ram_we    = host_we;
        end else begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = reset_n & cpu_req & cpu_we;
        end
        host_gnt  = host_win_s;
        cpu_stall = host_win_s & cpu_req;
    end

    // Counts CPU wins while the host waits; clears on a grant or when the host lets go.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_r <= 4'd0;
        end else if (!host_req || host_win_s) begin
            starve_cnt_r <= 4'd0;
        end else if (cpu_req && (starve_cnt_r < STARVE_LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Host read data is captured on the grant edge and flagged valid for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_rvalid_r <= 1'b0;
            host_rdata_r  <= 16'h0000;
        end else begin
            host_rvalid_r <= host_win_s & ~host_we;
            if (host_win_s && !host_we) begin
                host_rdata_r <= ram_rdata;
            end else begin
                host_rdata_r <= host_rdata_r;
            end
        end
    end

endmodule
